// File: rtl/phy_pattern_gen.sv
// Programmable burst/gap pattern source for the PHY TX path.
// Counter, replicated-nibble, Galois LFSR and constant patterns with ready back-pressure.
module phy_pattern_gen #(
  parameter int              WIDTH = 32,
  parameter int              CNT_W = 8,
  parameter logic [WIDTH-1:0] TAPS = 32'h80200003
) (
  input  logic             clk_f,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] burst_len,
  input  logic [CNT_W-1:0] gap_len,
  input  logic [CNT_W-1:0] num_bursts,
  input  logic [WIDTH-1:0] seed,
  input  logic             ready,
  output logic [WIDTH-1:0] data_out,
  output logic             valid_out,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BURST,
    S_GAP
  } state_t;

  localparam logic [1:0] M_CNT  = 2'd0;
  localparam logic [1:0] M_NIB  = 2'd1;
  localparam logic [1:0] M_LFSR = 2'd2;
  localparam logic [CNT_W-1:0] ONE = 1;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [1:0]       r_mode;
  logic [CNT_W-1:0] r_burst_len;
  logic [CNT_W-1:0] r_gap_len;
  logic [CNT_W-1:0] r_num_bursts;
  logic [CNT_W-1:0] r_word_cnt;
  logic [CNT_W-1:0] r_gap_cnt;
  logic [CNT_W-1:0] r_burst_cnt;
  logic [WIDTH-1:0] r_data;
  logic             r_valid;
  logic             r_busy;
  logic             r_done;

  logic [CNT_W-1:0] w_word_nxt;
  logic [CNT_W-1:0] w_gap_nxt;
  logic [CNT_W-1:0] w_bcnt_nxt;
  logic [WIDTH-1:0] w_data_nxt;
  logic             w_valid_nxt;
  logic             w_busy_nxt;
  logic             w_done_nxt;
  logic             w_cfg_ld;
  logic             w_xfer;
  logic             w_last_word;
  logic             w_last_burst;

  function automatic logic [WIDTH-1:0] f_first(
    input logic [1:0]       m,
    input logic [WIDTH-1:0] s
  );
    case (m)
      M_CNT:   f_first = s;
      M_NIB:   f_first = '1;
      M_LFSR:  f_first = (s == '0) ? '1 : s;
      default: f_first = s;
    endcase
  endfunction

  function automatic logic [WIDTH-1:0] f_next(
    input logic [1:0]       m,
    input logic [WIDTH-1:0] cur
  );
    logic [3:0] nib;
    nib = cur[3:0] - 4'd1;
    case (m)
      M_CNT:   f_next = cur + 1'b1;
      M_NIB:   f_next = {(WIDTH/4){nib}};
      M_LFSR:  f_next = cur[0] ? ((cur >> 1) ^ TAPS) : (cur >> 1);
      default: f_next = cur;
    endcase
  endfunction

  assign w_xfer       = r_valid & ready;
  assign w_last_word  = (r_word_cnt == r_burst_len - ONE);
  assign w_last_burst = (r_burst_cnt == r_num_bursts - ONE);

  always_comb begin
    w_state_nxt = r_state;
    w_data_nxt  = r_data;
    w_valid_nxt = r_valid;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_word_nxt  = r_word_cnt;
    w_gap_nxt   = r_gap_cnt;
    w_bcnt_nxt  = r_burst_cnt;
    w_cfg_ld    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_cfg_ld   = 1'b1;
          w_word_nxt = '0;
          w_gap_nxt  = '0;
          w_bcnt_nxt = '0;
          if (burst_len == '0 || num_bursts == '0) begin
            w_done_nxt = 1'b1;
          end else begin
            w_state_nxt = S_BURST;
            w_data_nxt  = f_first(mode, seed);
            w_valid_nxt = 1'b1;
            w_busy_nxt  = 1'b1;
          end
        end
      end
      S_BURST: begin
        if (w_xfer) begin
          w_data_nxt = f_next(r_mode, r_data);
          if (w_last_word) begin
            w_word_nxt = '0;
            if (w_last_burst) begin
              w_state_nxt = S_IDLE;
              w_valid_nxt = 1'b0;
              w_busy_nxt  = 1'b0;
              w_done_nxt  = 1'b1;
            end else begin
              w_bcnt_nxt = r_burst_cnt + ONE;
              // zero gap keeps valid high for back-to-back bursts
              if (r_gap_len != '0) begin
                w_state_nxt = S_GAP;
                w_valid_nxt = 1'b0;
                w_gap_nxt   = ONE;
              end
            end
          end else begin
            w_word_nxt = r_word_cnt + ONE;
          end
        end
      end
      S_GAP: begin
        if (r_gap_cnt == r_gap_len) begin
          w_state_nxt = S_BURST;
          w_valid_nxt = 1'b1;
        end else begin
          w_gap_nxt = r_gap_cnt + ONE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_valid_nxt = 1'b0;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_f or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk_f or posedge reset) begin
    if (reset) begin
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_word_cnt  <= '0;
      r_gap_cnt   <= '0;
      r_burst_cnt <= '0;
    end else begin
      r_data      <= w_data_nxt;
      r_valid     <= w_valid_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
      r_word_cnt  <= w_word_nxt;
      r_gap_cnt   <= w_gap_nxt;
      r_burst_cnt <= w_bcnt_nxt;
    end
  end

  always_ff @(posedge clk_f or posedge reset) begin
    if (reset) begin
      r_mode       <= '0;
      r_burst_len  <= '0;
      r_gap_len    <= '0;
      r_num_bursts <= '0;
    end else if (w_cfg_ld) begin
      r_mode       <= mode;
      r_burst_len  <= burst_len;
      r_gap_len    <= gap_len;
      r_num_bursts <= num_bursts;
    end
  end

  assign data_out  = r_data;
  assign valid_out = r_valid;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_phy_pattern_gen.sv
// Randomised self-checking bench for phy_pattern_gen.
// Words are compared against a pattern model indexed by transfer number.
module tb_phy_pattern_gen;

  localparam logic [31:0] TAPS = 32'h80200003;

  logic        clk_f = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  mode;
  logic [7:0]  burst_len;
  logic [7:0]  gap_len;
  logic [7:0]  num_bursts;
  logic [31:0] seed;
  logic        ready;
  logic [31:0] data_out;
  logic        valid_out;
  logic        busy;
  logic        done;

  int n_chk  = 0;
  int n_fail = 0;
  logic [31:0] obs[$];

  phy_pattern_gen dut (
    .clk_f(clk_f),
    .reset(reset),
    .start(start),
    .mode(mode),
    .burst_len(burst_len),
    .gap_len(gap_len),
    .num_bursts(num_bursts),
    .seed(seed),
    .ready(ready),
    .data_out(data_out),
    .valid_out(valid_out),
    .busy(busy),
    .done(done)
  );

  always #5 clk_f = ~clk_f;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_word(input int m,
                                             input logic [31:0] s,
                                             input int k);
    logic [31:0] w;
    logic [3:0]  nb;
    case (m)
      0: return s + 32'(k);
      1: begin
        nb = 4'(15 - (k % 16));
        return {8{nb}};
      end
      2: begin
        w = (s == 32'd0) ? 32'hFFFF_FFFF : s;
        for (int i = 0; i < k; i++)
          w = w[0] ? ((w >> 1) ^ TAPS) : (w >> 1);
        return w;
      end
      default: return s;
    endcase
  endfunction

  task automatic scramble_cfg();
    mode       = 2'($urandom_range(3));
    burst_len  = 8'($urandom);
    gap_len    = 8'($urandom);
    num_bursts = 8'($urandom);
    seed       = $urandom;
  endtask

  // Call at posedge+1; returns at posedge+1.
  task automatic run(input int m, input logic [31:0] s, input int bl,
                     input int gl, input int nb, input int pct,
                     input int stall_k, input int stall_n,
                     input bit poke, input bit b2b);
    int k, cyc, stalls, gaps, st_cnt;
    logic [31:0] held;
    bit was_valid, was_ready;
    obs.delete();
    mode = 2'(m); seed = s;
    burst_len = 8'(bl); gap_len = 8'(gl); num_bursts = 8'(nb);
    start = 1'b1;
    @(posedge clk_f); #1;
    start = 1'b0;
    scramble_cfg();
    if (bl == 0 || nb == 0) begin
      chk("zero_done", done, 1);
      chk("zero_valid", valid_out, 0);
      chk("zero_busy", busy, 0);
    end else begin
      k = 0; cyc = 0; stalls = 0; gaps = 0; st_cnt = 0;
      while (busy && cyc < 2000) begin
        cyc++;
        was_valid = valid_out;
        held = data_out;
        start = 1'b0;
        if (valid_out) begin
          chk("word", data_out, model_word(m, s, k));
          chk("busy_run", done, 0);
          if (k == stall_k && st_cnt < stall_n) begin
            ready = 1'b0;
            st_cnt++;
          end else begin
            ready = ($urandom_range(99) < pct);
          end
          if (!ready && poke) start = $urandom_range(1);
        end else begin
          gaps++;
          ready = $urandom_range(1);
          if (poke) start = $urandom_range(1);
        end
        was_ready = ready;
        @(posedge clk_f); #1;
        if (was_valid && was_ready) begin
          obs.push_back(held);
          k++;
        end else if (was_valid) begin
          stalls++;
          chk("stall_hold_v", valid_out, 1);
          chk("stall_hold_d", data_out, held);
        end
      end
      start = 1'b0;
      chk("run_timeout", 64'(cyc < 2000), 1);
      chk("end_done", done, 1);
      chk("end_valid", valid_out, 0);
      chk("end_busy", busy, 0);
      chk("n_words", 64'(k), 64'(nb * bl));
      chk("n_gap", 64'(gaps), 64'((nb - 1) * gl));
      chk("n_cycles", 64'(cyc), 64'(nb * bl + stalls + (nb - 1) * gl));
    end
    if (!b2b) begin
      @(posedge clk_f); #1;
      chk("done_pulse", done, 0);
      chk("idle_valid", valid_out, 0);
    end
  endtask

  logic [31:0] exp_tab[4];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; start = 1'b0; ready = 1'b1;
    scramble_cfg();
    repeat (3) @(posedge clk_f);
    #1;
    chk("rst_data", data_out, 0);
    chk("rst_valid", valid_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    @(negedge clk_f); reset = 1'b0;
    @(posedge clk_f); #1;

    // Nibble burst of four with literal values
    run(1, 32'h0, 4, 0, 1, 100, -1, 0, 0, 0);
    exp_tab = '{32'hFFFFFFFF, 32'hEEEEEEEE, 32'hDDDDDDDD, 32'hCCCCCCCC};
    chk("nib_cnt", obs.size(), 4);
    foreach (exp_tab[i])
      if (i < obs.size()) chk("nib_lit", obs[i], exp_tab[i]);

    // Counter, two bursts with a two-cycle gap
    run(0, 32'd3, 2, 2, 2, 100, -1, 0, 0, 0);
    exp_tab = '{32'd3, 32'd4, 32'd5, 32'd6};
    chk("cnt_cnt", obs.size(), 4);
    foreach (exp_tab[i])
      if (i < obs.size()) chk("cnt_lit", obs[i], exp_tab[i]);

    // Three-cycle stall on the second word
    run(0, 32'd0, 3, 0, 1, 100, 1, 3, 0, 0);
    chk("stall_cnt", obs.size(), 3);
    for (int i = 0; i < 3; i++)
      if (i < obs.size()) chk("stall_lit", obs[i], 32'(i));

    // LFSR with zero seed
    run(2, 32'd0, 3, 1, 1, 100, -1, 0, 0, 0);
    exp_tab = '{32'hFFFFFFFF, 32'hFFDFFFFC, 32'h7FEFFFFE, 32'h0};
    chk("lfsr_cnt", obs.size(), 3);
    for (int i = 0; i < 3; i++)
      if (i < obs.size()) chk("lfsr_lit", obs[i], exp_tab[i]);

    // Constant
    run(3, 32'hA5A5A5A5, 3, 0, 1, 100, -1, 0, 0, 0);
    chk("const_cnt", obs.size(), 3);
    for (int i = 0; i < 3; i++)
      if (i < obs.size()) chk("const_lit", obs[i], 32'hA5A5A5A5);

    // Zero-length runs, then start pokes while busy
    run(0, 32'd1, 0, 2, 3, 100, -1, 0, 0, 0);
    run(0, 32'd1, 2, 2, 0, 100, -1, 0, 0, 0);
    run(0, 32'd9, 3, 2, 3, 50, -1, 0, 1, 0);

    // Back-to-back start in the done cycle
    run(0, 32'd20, 2, 0, 2, 100, -1, 0, 0, 1);
    run(0, 32'd40, 2, 1, 1, 100, -1, 0, 0, 0);

    // Reset in the middle of the second burst
    mode = 2'd0; seed = 32'd0; burst_len = 8'd3;
    gap_len = 8'd2; num_bursts = 8'd3; ready = 1'b1;
    start = 1'b1;
    @(posedge clk_f); #1;
    start = 1'b0;
    repeat (5) @(posedge clk_f);
    #1;
    chk("mid_valid", valid_out, 1);
    chk("mid_data", data_out, 32'd3);
    #2 reset = 1'b1;
    #1;
    chk("arst_data", data_out, 0);
    chk("arst_valid", valid_out, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_f); #1;
      chk("arst_nodone", done, 0);
    end
    @(negedge clk_f); reset = 1'b0;
    @(posedge clk_f); #1;
    chk("post_rst_done", done, 0);
    run(0, 32'd7, 3, 1, 2, 100, -1, 0, 0, 0);
    chk("post_rst_first", obs.size() > 0 ? obs[0] : 32'hX, 32'd7);

    // Randomised runs
    for (int r = 0; r < 40; r++) begin
      run($urandom_range(3), $urandom, $urandom_range(6),
          $urandom_range(3), $urandom_range(3), $urandom_range(40, 100),
          $urandom_range(5), $urandom_range(3), $urandom_range(1),
          $urandom_range(1));
    end
    run(2, $urandom, 200, 0, 1, 90, -1, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/phy_pattern_gen.md
# phy_pattern_gen

Parametrised, synthesizable stimulus source for the PHY TX path. It emits programmable bursts of WIDTH-bit words with a valid strobe, separated by programmable idle gaps. Four data patterns are available: counter, descending replicated nibble (FFFF…, EEEE…), Galois LFSR and constant. It honours a ready back-pressure input and replaces hand-written stimulus sequences in PHY benches.

## Interface
Parameters:
- WIDTH, 32: data word width; must be a multiple of 4.
- CNT_W, 8: width of the burst, gap and burst-count configuration fields.
- TAPS, 32'h80200003: Galois LFSR feedback mask (WIDTH bits).

Ports:
- clk_f  input  1  single clock; all logic on its rising edge.
- reset  input  1  asynchronous, active-high; clears all state and outputs immediately.
- start  input  1  begin a run; sampled only in IDLE.
- mode  input  2  pattern: 0 counter, 1 nibble, 2 LFSR, 3 constant.
- burst_len  input  CNT_W  valid words per burst.
- gap_len  input  CNT_W  idle cycles between bursts.
- num_bursts  input  CNT_W  bursts per run.
- seed  input  WIDTH  initial word (modes 0, 2, 3).
- ready  input  1  sink accepts the current word.
- data_out  output  WIDTH  registered data word.
- valid_out  output  1  registered valid strobe.
- busy  output  1  high from the cycle after start is accepted until the run ends.
- done  output  1  one-cycle pulse at the end of a run.

## Operation
- FSM states: IDLE, BURST, GAP.
- A transfer occurs on a clock edge where valid_out=1 and ready=1.
- IDLE:
  - With start=1, latch mode, burst_len, gap_len, num_bursts and seed.
  - Go to BURST with the first word loaded.
  - If burst_len=0 or num_bursts=0, stay in IDLE instead and pulse done next cycle; valid_out never rises.
- BURST:
  - valid_out=1.
  - With ready=0, data_out and valid_out hold their values.
  - Each transfer advances the pattern and the word counter.
  - On the transfer of word burst_len of a burst:
    - Last burst: go to IDLE.
    - Otherwise, gap_len>0: go to GAP.
    - Otherwise, gap_len=0: remain in BURST, so the next burst follows back-to-back.
- GAP: valid_out=0 for exactly gap_len cycles, then BURST. The pattern does not advance during GAP.
- Patterns (k = transfers since start, continuous across bursts):
  - Mode 0: data = seed + k, modulo 2^WIDTH.
  - Mode 1: every nibble = (15 − k) mod 16, i.e. FFFF…, EEEE…, …, 0000…, then FFFF… again.
  - Mode 2: the first word is seed, or all ones if seed = 0. Next word = (cur>>1) ^ TAPS if cur[0] = 1, else cur>>1.
  - Mode 3: data = seed, constant.
- start while busy=1 is ignored; configuration inputs are ignored except at acceptance.
- reset asserted mid-run: all outputs return to 0 asynchronously, the FSM goes to IDLE and counters clear. No done pulse occurs. The first start after reset release begins a fresh run.

## Timing
- Reset values: data_out=0, valid_out=0, busy=0, done=0.
- Latency:
  - start sampled at edge N.
  - valid_out=1, busy=1 and the first word appear after edge N; the first transfer is possible at edge N+1.
- With ready held at 1, a run lasts num_bursts·burst_len + (num_bursts−1)·gap_len cycles of valid/gap activity.
- End of run:
  - The cycle after the final transfer has valid_out=0, busy=0 and done=1.
  - done is low the following cycle.
  - A new start may be sampled in that same done cycle.
- Zero-length run: start at edge N gives done=1 after edge N. busy stays 0.
- The word counter and the gap counter are CNT_W bits. The maximum burst_len and gap_len is 2^CNT_W − 1, with no wrap within a burst.

## Test plan
- Reset, then start with mode=1, burst_len=4, num_bursts=1, ready=1 → data_out FFFFFFFF, EEEEEEEE, DDDDDDDD, CCCCCCCC on 4 consecutive cycles. Next cycle: valid_out=0 and done=1.
- Mode 0, seed=3, burst_len=2, gap_len=2, num_bursts=2 → words 3, 4, then 2 idle cycles, then 5, 6, then done. busy is high for exactly 6 cycles.
- Mode 0, seed=0, burst_len=3; ready low on the 2nd word for 3 cycles → data_out holds 1 with valid_out=1 throughout the stall, then 2. Total words delivered: 0, 1, 2.
- Mode 2, seed=0, burst_len=3 → FFFFFFFF, then FFFFFFFF>>1 ^ 80200003 = FFDFFFFC, then 7FEFFFFE. Mode 3, seed=A5A5A5A5 → three words of A5A5A5A5.
- burst_len=0 → done pulse one cycle after start, valid_out stays 0. A start while busy changes nothing in the running sequence.
- Assert reset during the 2nd burst of a 3-burst run → outputs are 0 at once with no done pulse. After release, a start with mode=0, seed=7 begins at word 7.
